// File: rtl/adc16dv160_capture_ctrl.sv
// ADC16DV160 capture controller: arms on cr_start, optionally waits for a level-sync
// trigger, then frames samples onto an AXI-Stream master. Option: ADC16DV160_TRIG_TIMESTAMP_EN.
module adc16dv160_capture_ctrl #(
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [31:0]   dsize,
  input  logic          cr_start,
  input  logic          cr_test,
  input  logic          cr_rt,
  input  logic          cr_ls,
  input  logic [15:0]   ls_start_thr,
  input  logic [15:0]   ls_stop_thr,
  input  logic [31:0]   ls_n_start,
  input  logic [31:0]   ls_n_stop,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic          M_AXIS_TLAST,
  output logic          busy,
  output logic          overflow
`ifdef ADC16DV160_TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]   trig_ts,
  output logic          trig_ts_valid
`endif
);

  localparam int XW = (DW > 16) ? DW : 16;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [CW-1:0]  run_q, run_d;
  logic [CW-1:0]  stop_q, stop_d;
  logic [15:0]    tcnt_q, tcnt_d;
  logic [DW-1:0]  tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic           tlast_q, tlast_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;

  logic [DW-1:0]        smp;
  logic signed [XW-1:0] smp_x, sthr_x, pthr_x;
  logic [CW-1:0]        n_start_eff, n_stop_eff, run_inc, stop_inc;
  logic                 active, out_free, accept, drop, stop_en;
  logic                 emit, early, last, load;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Sample selection and signed threshold compares
  assign smp         = cr_test ? DW'(tcnt_q) : adc_data;
  assign smp_x       = XW'($signed(smp));
  assign sthr_x      = XW'($signed(ls_start_thr));
  assign pthr_x      = XW'($signed(ls_stop_thr));
  assign n_start_eff = (ls_n_start == 32'd0) ? CW'(1) : CW'(ls_n_start);
  assign n_stop_eff  = CW'(ls_n_stop);
  assign stop_en     = cr_ls && (ls_n_stop != 32'd0);

  assign active   = (state_q != IDLE);
  assign out_free = !tvalid_q || M_AXIS_TREADY;
  assign accept   = adc_valid && active && out_free;
  assign drop     = adc_valid && active && !out_free;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    run_d    = run_q;
    stop_d   = stop_q;
    tcnt_d   = tcnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    ovf_d    = ovf_q;
    emit     = 1'b0;
    early    = 1'b0;
    last     = 1'b0;
    load     = 1'b0;
    run_inc  = sat_inc(run_q);
    stop_inc = sat_inc(stop_q);

    if (adc_valid) tcnt_d = tcnt_q + 16'd1;
    if (drop) ovf_d = 1'b1;
    if (tvalid_q && M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cr_start && (dsize != 32'd0)) begin
          load    = 1'b1;
          ovf_d   = 1'b0;
          tcnt_d  = adc_valid ? 16'd1 : 16'd0;
          state_d = cr_ls ? WAIT_TRIG : CAPTURE;
        end
      end
      WAIT_TRIG: begin
        if (accept) begin
          if (smp_x > sthr_x) begin
            run_d = run_inc;
            emit  = (run_inc >= n_start_eff);
          end else begin
            run_d = '0;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          emit = 1'b1;
          if (stop_en && (smp_x < pthr_x)) begin
            stop_d = stop_inc;
            early  = (stop_inc >= n_stop_eff);
          end else begin
            stop_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register load; frame end decides re-arm vs. idle
    if (emit) begin
      tdata_d  = smp;
      tvalid_d = 1'b1;
      rem_d    = rem_q - CW'(1);
      last     = (rem_q == CW'(1)) || early;
      tlast_d  = last;
      if (last) begin
        if (cr_rt && (dsize != 32'd0)) begin
          load    = 1'b1;
          state_d = cr_ls ? WAIT_TRIG : CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end else begin
        state_d = CAPTURE;
      end
    end

    if (load) begin
      rem_d  = CW'(dsize);
      run_d  = '0;
      stop_d = '0;
    end

    busy_d = (state_d != IDLE) || tvalid_d;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      run_q    <= '0;
      stop_q   <= '0;
      tcnt_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      run_q    <= run_d;
      stop_q   <= stop_d;
      tcnt_q   <= tcnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;

`ifdef ADC16DV160_TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] trig_ts_q, trig_ts_d;
  logic        first_q, first_d;
  logic        tsv_q, tsv_d;

  // first_q marks that the next emitted word opens a frame
  always_comb begin
    ts_cnt_d  = ts_cnt_q;
    first_d   = first_q;
    trig_ts_d = trig_ts_q;
    tsv_d     = 1'b0;
    if (adc_valid) ts_cnt_d = ts_cnt_q + 32'd1;
    if (emit && first_q) begin
      trig_ts_d = ts_cnt_q;
      tsv_d     = 1'b1;
    end
    if (emit) first_d = 1'b0;
    if (load) first_d = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ts_cnt_q  <= '0;
      first_q   <= 1'b0;
      trig_ts_q <= '0;
      tsv_q     <= 1'b0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      first_q   <= first_d;
      trig_ts_q <= trig_ts_d;
      tsv_q     <= tsv_d;
    end
  end

  assign trig_ts       = trig_ts_q;
  assign trig_ts_valid = tsv_q;
`endif

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
// Directed bench for adc16dv160_capture_ctrl: one task per scenario, delivered
// words collected by a handshake monitor and compared with hand-computed frames.
module tb_adc16dv160_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [31:0] dsize;
  logic        cr_start, cr_test, cr_rt, cr_ls;
  logic [15:0] ls_start_thr, ls_stop_thr;
  logic [31:0] ls_n_start, ls_n_stop;
  logic [15:0] tdata;
  logic        tvalid, tready, tlast, busy, overflow;
`ifdef ADC16DV160_TRIG_TIMESTAMP_EN
  logic [31:0] trig_ts;
  logic        trig_ts_valid;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q_d[$];
  bit          q_l[$];

  adc16dv160_capture_ctrl #(.DW(16), .CW(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .dsize(dsize), .cr_start(cr_start), .cr_test(cr_test), .cr_rt(cr_rt), .cr_ls(cr_ls),
    .ls_start_thr(ls_start_thr), .ls_stop_thr(ls_stop_thr),
    .ls_n_start(ls_n_start), .ls_n_stop(ls_n_stop),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast), .busy(busy), .overflow(overflow)
`ifdef ADC16DV160_TRIG_TIMESTAMP_EN
    , .trig_ts(trig_ts), .trig_ts_valid(trig_ts_valid)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so at negedge they already hold the next edge's values.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      q_d.push_back(tdata);
      q_l.push_back(tlast);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adc_data = '0; adc_valid = 1'b0; dsize = '0;
    cr_start = 1'b0; cr_test = 1'b0; cr_rt = 1'b0; cr_ls = 1'b0;
    ls_start_thr = '0; ls_stop_thr = '0; ls_n_start = '0; ls_n_stop = '0;
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (tdata !== 16'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0000", tdata); end
    n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    n_vec++; if (tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", tlast); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_free_run();
    q_d.delete(); q_l.delete();
    cr_test = 1'b1; cr_ls = 1'b0; cr_rt = 1'b0; dsize = 32'd4; tready = 1'b1;
    adc_valid = 1'b1; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL free_busy_armed got %b want 1", busy); end
    n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL free_tvalid_early got %b want 0", tvalid); end
    tick();
    n_vec++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL free_latency_tvalid got %b want 1", tvalid); end
    n_vec++; if (tdata !== 16'd1) begin n_err++; $display("FAIL free_first_tdata got %0d want 1", tdata); end
    repeat (6) tick();
    adc_valid = 1'b0; cr_test = 1'b0;
    n_vec++; if (q_d.size() != 4) begin n_err++; $display("FAIL free_count got %0d want 4", q_d.size()); end
    for (int i = 0; i < 4 && i < q_d.size(); i++) begin
      n_vec++;
      if (q_d[i] !== 16'(i + 1) || q_l[i] !== (i == 3)) begin
        n_err++; $display("FAIL free_word%0d got %0d/last%b want %0d/last%b", i, q_d[i], q_l[i], i + 1, (i == 3));
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL free_busy_end got %b want 0", busy); end
  endtask

  task automatic test_level_trigger();
    int v[11];
    int e[5];
    v = '{50, 120, 130, 90, 110, 120, 140, 10, 20, 30, 55};
    e = '{140, 10, 20, 30, 55};
    q_d.delete(); q_l.delete();
    cr_test = 1'b0; cr_ls = 1'b1; cr_rt = 1'b0; dsize = 32'd5; tready = 1'b1;
    ls_start_thr = 16'd100; ls_n_start = 32'd3; ls_n_stop = 32'd0; ls_stop_thr = 16'd0;
    adc_valid = 1'b0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      adc_valid = 1'b1; adc_data = 16'(v[i]);
      tick();
    end
    adc_valid = 1'b0;
    repeat (4) tick();
    n_vec++; if (q_d.size() != 5) begin n_err++; $display("FAIL trig_count got %0d want 5", q_d.size()); end
    for (int i = 0; i < 5 && i < q_d.size(); i++) begin
      n_vec++;
      if (q_d[i] !== 16'(e[i]) || q_l[i] !== (i == 4)) begin
        n_err++; $display("FAIL trig_word%0d got %0d/last%b want %0d/last%b", i, q_d[i], q_l[i], e[i], (i == 4));
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL trig_busy_end got %b want 0", busy); end
  endtask

  task automatic test_early_stop();
    int v[7];
    int e[4];
    v = '{200, 10, -60, -70, 1, 2, 3};
    e = '{200, 10, -60, -70};
    q_d.delete(); q_l.delete();
    cr_ls = 1'b1; cr_rt = 1'b0; dsize = 32'd100; tready = 1'b1;
    ls_start_thr = 16'd100; ls_n_start = 32'd1; ls_stop_thr = 16'hFFCE; ls_n_stop = 32'd2;
    adc_valid = 1'b0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      adc_valid = 1'b1; adc_data = 16'(v[i]);
      tick();
    end
    adc_valid = 1'b0;
    repeat (3) tick();
    n_vec++; if (q_d.size() != 4) begin n_err++; $display("FAIL stop_count got %0d want 4", q_d.size()); end
    for (int i = 0; i < 4 && i < q_d.size(); i++) begin
      n_vec++;
      if (q_d[i] !== 16'(e[i]) || q_l[i] !== (i == 3)) begin
        n_err++; $display("FAIL stop_word%0d got %h/last%b want %h/last%b", i, q_d[i], q_l[i], 16'(e[i]), (i == 3));
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy_end got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    q_d.delete(); q_l.delete();
    cr_ls = 1'b0; cr_rt = 1'b0; dsize = 32'd3; tready = 1'b1; ls_n_stop = 32'd0;
    adc_valid = 1'b0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    adc_valid = 1'b1; adc_data = 16'd11; tick();
    tready = 1'b0; adc_data = 16'd12; tick();
    n_vec++; if (tdata !== 16'd11 || tvalid !== 1'b1) begin n_err++; $display("FAIL bp_hold got %0d/v%b want 11/v1", tdata, tvalid); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow_set got %b want 1", overflow); end
    adc_data = 16'd13; tick();
    adc_data = 16'd14; tick();
    tready = 1'b1; adc_data = 16'd15; tick();
    adc_data = 16'd16; tick();
    adc_data = 16'd17; tick();
    adc_valid = 1'b0;
    repeat (2) tick();
    n_vec++; if (q_d.size() != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", q_d.size()); end
    if (q_d.size() == 3) begin
      n_vec++; if (q_d[0] !== 16'd11 || q_l[0] !== 1'b0) begin n_err++; $display("FAIL bp_word0 got %0d/last%b want 11/last0", q_d[0], q_l[0]); end
      n_vec++; if (q_d[1] !== 16'd15 || q_l[1] !== 1'b0) begin n_err++; $display("FAIL bp_word1 got %0d/last%b want 15/last0", q_d[1], q_l[1]); end
      n_vec++; if (q_d[2] !== 16'd16 || q_l[2] !== 1'b1) begin n_err++; $display("FAIL bp_word2 got %0d/last%b want 16/last1", q_d[2], q_l[2]); end
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow_sticky got %b want 1", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end got %b want 0", busy); end
  endtask

  task automatic test_continuous();
    q_d.delete(); q_l.delete();
    cr_ls = 1'b0; cr_rt = 1'b1; dsize = 32'd2; tready = 1'b1;
    adc_valid = 1'b0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) cr_rt = 1'b0;
      adc_valid = 1'b1; adc_data = 16'(i);
      tick();
    end
    adc_valid = 1'b0;
    repeat (3) tick();
    n_vec++; if (q_d.size() != 6) begin n_err++; $display("FAIL cont_count got %0d want 6", q_d.size()); end
    for (int i = 0; i < 6 && i < q_d.size(); i++) begin
      n_vec++;
      if (q_d[i] !== 16'(i + 1) || q_l[i] !== (i % 2 == 1)) begin
        n_err++; $display("FAIL cont_word%0d got %0d/last%b want %0d/last%b", i, q_d[i], q_l[i], i + 1, (i % 2 == 1));
      end
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cont_overflow_cleared got %b want 0", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_busy_end got %b want 0", busy); end
    q_d.delete(); q_l.delete();
    dsize = 32'd0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_dsize_busy got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1; adc_data = 16'(100 + i);
      tick();
    end
    adc_valid = 1'b0;
    repeat (2) tick();
    n_vec++; if (q_d.size() != 0) begin n_err++; $display("FAIL zero_dsize_words got %0d want 0", q_d.size()); end
  endtask

  task automatic test_reset_mid_frame();
    q_d.delete(); q_l.delete();
    cr_ls = 1'b0; cr_rt = 1'b0; dsize = 32'd100; tready = 1'b1;
    adc_valid = 1'b0; cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
    adc_valid = 1'b1; adc_data = 16'd5; tick();
    adc_data = 16'd6; tick();
    n_vec++; if (busy !== 1'b1 || tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_active got busy%b/v%b want 1/1", busy, tvalid); end
    tready = 1'b0; adc_data = 16'd7; tick();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rstmid_overflow_pre got %b want 1", overflow); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", tvalid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    n_vec++; if (tlast !== 1'b0) begin n_err++; $display("FAIL rstmid_tlast got %b want 0", tlast); end
    tick();
    rst = 1'b0;
    q_d.delete(); q_l.delete();
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_data = 16'(20 + i);
      tick();
    end
    adc_valid = 1'b0;
    repeat (2) tick();
    n_vec++; if (q_d.size() != 0) begin n_err++; $display("FAIL rstmid_abandoned got %0d words want 0", q_d.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_level_trigger();
    test_early_stop();
    test_backpressure();
    test_continuous();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc16dv160_capture_ctrl.md
Name: adc16dv160_capture_ctrl

Overview:
- Capture controller directly downstream of the AXI-Lite control-register write stage.
- Consumes its register outputs (dsize, cr_start, cr_test, cr_rt, cr_ls, ls_* thresholds/counts) and the 16-bit ADC16DV160 sample stream.
- Arms on a start pulse, optionally waits for a level-sync trigger, then emits framed sample bursts on an AXI-Stream master that feeds the DMA.

Parameters:
- DW, 16, sample/TDATA width (two's complement).
- CW, 32, width of frame-length and run counters.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- adc_data  in  DW  ADC sample, two's complement
- adc_valid  in  1  sample strobe, at most one per cycle
- dsize  in  32  frame length in samples
- cr_start  in  1  one-cycle start pulse
- cr_test  in  1  1 = substitute test counter for adc_data
- cr_rt  in  1  1 = continuous, re-arm after each frame
- cr_ls  in  1  1 = level-sync trigger/stop enabled
- ls_start_thr  in  16  start threshold, signed
- ls_stop_thr  in  16  stop threshold, signed
- ls_n_start  in  32  consecutive samples above start threshold needed to trigger
- ls_n_stop  in  32  consecutive samples below stop threshold needed to stop; 0 disables early stop
- M_AXIS_TDATA  out  DW  sample
- M_AXIS_TVALID  out  1
- M_AXIS_TREADY  in  1
- M_AXIS_TLAST  out  1  last sample of frame
- busy  out  1  state != IDLE
- overflow  out  1  sticky, sample dropped due to backpressure

Behaviour:
- Reset: state IDLE; TDATA 0, TVALID 0, TLAST 0, busy 0, overflow 0; all counters 0.
- States: IDLE, WAIT_TRIG, CAPTURE.
- Accept rule:
  - A sample is accepted when adc_valid=1, state is WAIT_TRIG or CAPTURE, and the output register is free (TVALID=0 or TREADY=1).
  - adc_valid=1 with the register occupied and TREADY=0: sample dropped, overflow set. Dropped samples do not touch any counter except the test counter.
- Test counter: 16-bit; cleared on an accepted cr_start; increments on every adc_valid; wraps 0xFFFF->0x0000. When cr_test=1 it replaces adc_data.
- IDLE:
  - cr_start=1 with dsize!=0: load remaining=dsize, clear run counters and overflow; go to WAIT_TRIG if cr_ls=1, else CAPTURE.
  - cr_start with dsize=0: ignored.
- cr_start outside IDLE: ignored.
- WAIT_TRIG:
  - Each accepted sample: if signed sample > ls_start_thr, run++; else run=0. Sample is not emitted.
  - When run reaches max(ls_n_start,1), that sample is emitted as the first frame word in the same cycle, remaining decrements, and state goes to CAPTURE.
- CAPTURE:
  - Each accepted sample loads the output register next cycle: TVALID=1, remaining--.
  - Sample path latency: adc_valid at cycle N -> TVALID/TDATA at N+1.
  - TLAST=1 when remaining==1 before decrement.
  - If cr_ls=1 and ls_n_stop!=0: stop run counts samples with signed sample < ls_stop_thr and resets on any other sample. The sample completing ls_n_stop gets TLAST=1 (early end).
  - Both end conditions on one sample: a single TLAST.
- After a TLAST sample:
  - cr_rt=1: reload remaining=dsize, clear run counters, go to WAIT_TRIG (cr_ls=1) or stay in CAPTURE (cr_ls=0).
  - cr_rt=0: go to IDLE.
  - cr_rt is sampled at the TLAST cycle, so clearing it mid-frame finishes the current frame.
  - If dsize=0 at reload: go to IDLE.
- Output register holds TDATA/TLAST stable while TVALID=1 and TREADY=0. TVALID drops the cycle after a handshake with no new sample.
- busy stays 1 until the final TLAST word has handshaken.
- ARESET asserted mid-frame: immediate return to reset values; the partial frame is abandoned with no TLAST.
- Threshold and count inputs are read live. dsize is read only at load/reload.

Optional Feature:
- Macro ADC16DV160_TRIG_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit sample counter, reset 0, incremented on every adc_valid, wraps.
  - Adds output trig_ts[31:0], reset 0, loaded with the counter value of the first sample of each frame.
  - Adds output trig_ts_valid, a one-cycle pulse coincident with that load.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Free run, no backpressure: cr_ls=0, cr_rt=0, cr_test=1, dsize=4, adc_valid every cycle, TREADY=1 -> TDATA 1,2,3,4 (counter increments on the cr_start-cycle sample), TLAST on 4th, then IDLE, busy=0.
- Level trigger: cr_ls=1, ls_start_thr=100, ls_n_start=3, ls_n_stop=0, dsize=5; input 50,120,130,90,110,120,140,10,20,30 -> frame 140,10,20,30 plus next sample, TLAST on 5th.
- Early stop: ls_stop_thr=-50, ls_n_stop=2, dsize=100, samples after trigger 10,-60,-70 -> frame ends with TLAST on -70.
- Backpressure: dsize=3, TREADY=0 for 3 cycles during capture -> overflow=1, dropped samples skipped, exactly 3 words delivered, TLAST on 3rd.
- Continuous: cr_rt=1, cr_ls=0, dsize=2, 6 samples -> three 2-word frames; clear cr_rt during 3rd frame -> IDLE after its TLAST. Also cr_start with dsize=0 -> stays IDLE.
- Reset mid-frame: ARESET during CAPTURE -> TVALID=0, busy=0, overflow=0 immediately.
